// File: rtl/exhaustive_sweep_gen.sv
// Exhaustive stimulus sweeper with a 16-bit MISR response compactor.
// Define SWEEP_GRAY_EN for Gray-code pattern ordering (binary otherwise).
module exhaustive_sweep_gen #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 2,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [OUT_W-1:0] resp,
    input  logic [15:0]      golden,
    output logic [IN_W-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature,
    output logic             pass
);

    localparam int CW = IN_W + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] LAST = {1'b0, {IN_W{1'b1}}};
    localparam logic [HW-1:0] HEND = HW'(HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold;
    logic [CW-1:0] cnt_nxt;
    logic [15:0]   sig_fold;
    logic          hold_end;
    logic          last;

    function automatic logic [IN_W-1:0] map(input logic [CW-1:0] c);
        logic [CW-1:0] t;
`ifdef SWEEP_GRAY_EN
        t = c ^ (c >> 1);
`else
        t = c;
`endif
        return t[IN_W-1:0];
    endfunction

    always_comb begin
        hold_end = (hold == HEND);
        last     = (cnt == LAST);
        cnt_nxt  = cnt + 1'b1;
        sig_fold = {signature[14:0], 1'b0}
                 ^ (signature[15] ? 16'h1021 : 16'h0000)
                 ^ 16'(resp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hold      <= '0;
            stim      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            signature <= 16'hFFFF;
            pass      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        hold      <= '0;
                        stim      <= map('0);
                        signature <= 16'hFFFF;
                        pass      <= 1'b0;
                    end
                end
                RUN: begin
                    // abort wins over completion and leaves the MISR untouched
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        stim  <= '0;
                        cnt   <= '0;
                        hold  <= '0;
                    end else if (hold_end) begin
                        hold      <= '0;
                        signature <= sig_fold;
                        if (last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (sig_fold == golden);
                            stim  <= '0;
                            cnt   <= '0;
                        end else begin
                            cnt  <= cnt_nxt;
                            stim <= map(cnt_nxt);
                        end
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exhaustive_sweep_gen.sv
// Directed bench for exhaustive_sweep_gen: default instance plus an
// IN_W=2 instance with resp tied low for the known-signature check.
module tb_exhaustive_sweep_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] golden = 16'h0;
    logic [1:0]  resp;
    logic [3:0]  stim;
    logic        busy, done, pass;
    logic [15:0] sig;

    logic        start2 = 1'b0;
    logic [15:0] golden2 = 16'h0;
    logic [1:0]  resp2;
    logic [1:0]  stim2;
    logic        busy2, done2, pass2;
    logic [15:0] sig2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign resp  = stim[1:0] ^ stim[3:2];
    assign resp2 = 2'b00;

    exhaustive_sweep_gen u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .resp(resp), .golden(golden), .stim(stim), .busy(busy),
        .done(done), .signature(sig), .pass(pass)
    );

    exhaustive_sweep_gen #(.IN_W(2), .OUT_W(2), .HOLD(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .resp(resp2), .golden(golden2), .stim(stim2), .busy(busy2),
        .done(done2), .signature(sig2), .pass(pass2)
    );

    function automatic logic [3:0] map_tb(input int i);
        logic [3:0] b;
        b = i[3:0];
`ifdef SWEEP_GRAY_EN
        b = b ^ (b >> 1);
`endif
        return b;
    endfunction

    // expected MISR after n folds, resp = stim[1:0]^stim[3:2]
    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] s;
        logic [3:0]  p;
        logic [1:0]  r;
        s = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            p = map_tb(i);
            r = p[1:0] ^ p[3:2];
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {14'b0, r};
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || stim !== 4'h0) begin
            bad++;
            $display("FAIL reset_ctl: busy=%b done=%b stim=%h want 0 0 0", busy, done, stim);
        end
        total++;
        if (sig !== 16'hFFFF || pass !== 1'b0) begin
            bad++;
            $display("FAIL reset_sig: sig=%h pass=%b want ffff 0", sig, pass);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick(); tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: busy=%b want 0", busy);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] prev;
        golden = model_sig(16);
        pulse_start();
        prev = 4'h0;
        for (int c = 0; c < 32; c++) begin
            total++;
            if (stim !== map_tb(c / 2) || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL sweep_c%0d: stim=%h busy=%b done=%b want %h 1 0",
                         c, stim, busy, done, map_tb(c / 2));
            end
`ifdef SWEEP_GRAY_EN
            if (c > 0 && (c % 2) == 0) begin
                total++;
                if ($countones(stim ^ prev) != 1) begin
                    bad++;
                    $display("FAIL gray_step%0d: prev=%h stim=%h want one bit", c, prev, stim);
                end
            end
`endif
            prev = stim;
            tick();
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || stim !== 4'h0) begin
            bad++;
            $display("FAIL sweep_end: done=%b busy=%b stim=%h want 1 0 0", done, busy, stim);
        end
        total++;
        if (sig !== model_sig(16) || pass !== 1'b1) begin
            bad++;
            $display("FAIL sweep_sig: sig=%h pass=%b want %h 1", sig, pass, model_sig(16));
        end
        tick();
        total++;
        if (done !== 1'b0 || pass !== 1'b1 || sig !== model_sig(16)) begin
            bad++;
            $display("FAIL sweep_hold: done=%b pass=%b sig=%h want 0 1 %h",
                     done, pass, sig, model_sig(16));
        end
    endtask

    task automatic test_back_to_back();
        golden = ~model_sig(16);
        @(negedge clk);
        start = 1'b1;
        tick();
        for (int c = 0; c < 32; c++) begin
            total++;
            if (stim !== map_tb(c / 2) || busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_c%0d: stim=%h busy=%b want %h 1", c, stim, busy, map_tb(c / 2));
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: done=%b busy=%b pass=%b want 1 0 0", done, busy, pass);
        end
        tick();
        total++;
        if (busy !== 1'b1 || stim !== 4'h0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_restart: busy=%b stim=%h done=%b want 1 0 0", busy, stim, done);
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_abort: busy=%b want 0", busy);
        end
    endtask

    task automatic test_abort();
        int busy_cnt;
        int done_cnt;
        pulse_start();
        for (int c = 0; c < 10; c++) tick();
        total++;
        if (stim !== map_tb(5)) begin
            bad++;
            $display("FAIL abort_pre: stim=%h want %h", stim, map_tb(5));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || stim !== 4'h0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_ctl: busy=%b stim=%h done=%b want 0 0 0", busy, stim, done);
        end
        total++;
        if (sig !== model_sig(5) || pass !== 1'b0) begin
            bad++;
            $display("FAIL abort_sig: sig=%h pass=%b want %h 0", sig, pass, model_sig(5));
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_nodone: done=%b busy=%b want 0 0", done, busy);
        end
        // full sweep after abort, bounded wait
        golden = model_sig(16);
        pulse_start();
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 40 && done_cnt == 0; c++) begin
            if (busy) busy_cnt++;
            tick();
            if (done) done_cnt++;
        end
        total++;
        if (busy_cnt != 32 || done_cnt != 1 || pass !== 1'b1) begin
            bad++;
            $display("FAIL abort_rerun: busy_cycles=%0d done=%0d pass=%b want 32 1 1",
                     busy_cnt, done_cnt, pass);
        end
        // abort on the final cycle beats completion
        pulse_start();
        for (int c = 0; c < 31; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || sig !== model_sig(15)) begin
            bad++;
            $display("FAIL abort_last: done=%b busy=%b sig=%h want 0 0 %h",
                     done, busy, sig, model_sig(15));
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        for (int c = 0; c < 18; c++) tick();
        total++;
        if (stim !== map_tb(9) || busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre: stim=%h busy=%b want %h 1", stim, busy, map_tb(9));
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || stim !== 4'h0 || sig !== 16'hFFFF || pass !== 1'b0) begin
            bad++;
            $display("FAIL rstmid: busy=%b stim=%h sig=%h pass=%b want 0 0 ffff 0",
                     busy, stim, sig, pass);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_release: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_small_width();
        golden2 = 16'h0E1F;
        for (int run = 0; run < 2; run++) begin
            @(negedge clk);
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            for (int c = 0; c < 8; c++) begin
                total++;
                if (stim2 !== 2'(c / 2) || busy2 !== 1'b1) begin
                    bad++;
                    $display("FAIL w2_r%0d_c%0d: stim=%h busy=%b want %h 1",
                             run, c, stim2, busy2, c / 2);
                end
                tick();
            end
            total++;
            if (done2 !== 1'b1 || sig2 !== 16'h0E1F) begin
                bad++;
                $display("FAIL w2_r%0d_sig: done=%b sig=%h want 1 0e1f", run, done2, sig2);
            end
            total++;
            if (pass2 !== (run == 0)) begin
                bad++;
                $display("FAIL w2_r%0d_pass: pass=%b want %b", run, pass2, run == 0);
            end
            golden2 = 16'h0000;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_small_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
